// File: rtl/data_mem_responder.sv
// Multi-cycle MEM-stage data memory with valid/ready request and response handshakes.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses on resp_err instead of force-aligning them.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT       = 4'(LATENCY);
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [31:0]   load_data;
    logic [4:0]    lane_lsb;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic          misalign;
    logic          mem_we;
    logic          unused_addr_bits;

    // Upper address bits are dropped so accesses wrap modulo the array.
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign word_idx = addr_q[AW+1:2];
    assign rd_word  = mem_q[word_idx];
    assign lane_lsb = {addr_q[1:0], 3'b000};
    assign byte_sel = rd_word[lane_lsb +: 8];
    assign half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((size_q == SIZE_HALF) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    // Without the trap, the lane selection below ignores the misaligned low bits.
    assign misalign = 1'b0;
`endif

    // Lane merge for stores and lane extract/extend for loads.
    always_comb begin
        wr_word   = rd_word;
        load_data = rd_word;
        case (size_q)
            SIZE_BYTE: begin
                wr_word[lane_lsb +: 8] = wdata_q[7:0];
                load_data              = {{24{signed_q & byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                if (addr_q[1]) begin
                    wr_word[31:16] = wdata_q[15:0];
                end else begin
                    wr_word[15:0] = wdata_q[15:0];
                end
                load_data = {{16{signed_q & half_sel[15]}}, half_sel};
            end
            default: begin
                wr_word   = wdata_q;
                load_data = rd_word;
            end
        endcase
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;
        req_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = !Reset;
                if (req_valid && !Reset) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr[AW+1:0];
                    wdata_d  = req_wdata;
                    cnt_d    = LAT;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // A reset on the commit edge must keep the pending store out of memory.
                    mem_we       = write_q && !misalign && !Reset;
                    resp_rdata_d = (write_q || misalign) ? 32'h0 : load_data;
                    resp_err_d   = misalign;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // NOTE: the array is deliberately outside reset so stored data survives a Reset pulse.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2, DEPTH_WORDS=128).
// Expected misaligned-access results follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_data_mem_responder;
    localparam int DEPTH = 128;
    localparam int LAT   = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int tests = 0;
    int fails = 0;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .Clk       (clk),
        .Reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request, waits for the response and samples it; handshakes only if resp_ready=1.
    task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int   wait_n;
        logic busy_ok;
        wait_n     = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        while (!req_ready && wait_n < 20) begin
            tick();
            wait_n++;
        end
        tick();
        req_valid = 1'b0;
        busy_ok   = 1'b1;
        lat       = 0;
        while (!resp_valid && lat < 40) begin
            if (req_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (req_ready) busy_ok = 1'b0;
        rd = resp_rdata;
        er = resp_err;
        check("busy_req_ready", 32'(busy_ok), 32'd1);
        tick();
        if (resp_ready) check("post_hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        access(wr, sz, sg, addr, wd, rd, er, lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_lat"}, 32'(lat), 32'(LAT + 1));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] w10;
        logic        er;
        int          lat;
        logic        stable;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);

        // Word, byte and half stores with signed/unsigned loads.
        op("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        op("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        op("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345680, 32'h0, 1'b0);
        op("lb11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
        op("lbu11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h00000080, 1'b0);
        op("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
        op("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD8001, 32'h0, 1'b0);
        op("lh12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0);
        op("lhu12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00008001, 1'b0);
        op("lw10h", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h800180EF, 1'b0);

        // Backpressure: response held for 5 cycles while a stray store request is pulsed.
        resp_ready = 1'b0;
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("bp_rdata", rd, 32'h800180EF);
        check("bp_lat", 32'(lat), 32'(LAT + 1));
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_size  = 2'b10;
                req_addr  = 32'h10;
                req_wdata = 32'h0;
            end
            if (i == 3) req_valid = 1'b0;
            if (!resp_valid || resp_rdata !== 32'h800180EF || resp_err !== 1'b0 || req_ready)
                stable = 1'b0;
            tick();
        end
        req_valid = 1'b0;
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_still_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        tick();
        check("bp_hs_valid", 32'(resp_valid), 32'd0);
        check("bp_hs_ready", 32'(req_ready), 32'd1);
        op("bp_lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h800180EF, 1'b0);

        // Misaligned accesses: trapped, or force-aligned and performed.
        op("lw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, TRAP ? 32'h0 : 32'h800180EF, TRAP);
        op("lh13", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, TRAP ? 32'h0 : 32'hFFFF8001, TRAP);
        op("sh11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h00007777, 32'h0, TRAP);
        w10 = TRAP ? 32'h800180EF : 32'h80017777;
        op("lw10m", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, w10, 1'b0);

        // Address wrap modulo the array.
        op("lw210", 1'b0, 2'b10, 1'b0, 32'h210, 32'h0, w10, 1'b0);
        op("lwFE10", 1'b0, 2'b10, 1'b0, 32'hFFFFFE10, 32'h0, w10, 1'b0);

        // Reset in the first WAIT cycle drops the store.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        check("rw1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        check("rw1_valid", 32'(resp_valid), 32'd0);
        check("rw1_ready_rst", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rw1_ready_rel", 32'(req_ready), 32'd1);
        op("rw1_lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // Reset on the commit edge (last WAIT cycle) also drops the store.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h24;
        req_wdata = 32'hA5A5A5A5;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rw2_not_yet", 32'(resp_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rw2_valid", 32'(resp_valid), 32'd0);
        check("rw2_rdata", resp_rdata, 32'h0);
        op("rw2_lw24", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h0, 1'b0);

        // Reset in RESP drops the response but keeps the committed store.
        resp_ready = 1'b0;
        access(1'b1, 2'b10, 1'b0, 32'h28, 32'hCAFEF00D, rd, er, lat);
        check("rr_lat", 32'(lat), 32'(LAT + 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rr_valid", 32'(resp_valid), 32'd0);
        check("rr_ready", 32'(req_ready), 32'd1);
        resp_ready = 1'b1;
        op("rr_lw28", 1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the pipelined MIPS datapath's MEM stage. Accepts one load/store request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs the access against an internal word array with byte/halfword lane handling and load sign/zero extension. It returns a held response, either read data or a store acknowledge, under valid/ready backpressure. It is the responding end of the MEM-stage memory interface and replaces the single-cycle DataMemory so stall logic can be exercised.

## Interface
- DEPTH_WORDS, 128: number of 32-bit words; power of two, 4 to 4096.
- LATENCY, 2: wait-state cycles before the access commits; 0 to 15.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or low half is used for sub-word stores.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned access; only with the trap macro.

## Operation
- FSM states and transitions:
  - IDLE: req_ready=1. When req_valid&req_ready, latch all req_* fields, load counter=LATENCY, go to WAIT.
  - WAIT: while counter≠0, decrement it. When counter==0, commit the access at that edge and go to RESP.
  - RESP: resp_valid=1, outputs stable. When resp_valid&resp_ready, go to IDLE.
- Addressing:
  - Word index is addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo the array.
  - Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1].
- Stores:
  - Byte store writes only the selected 8-bit lane; half store writes only the selected 16-bit lane.
  - All other lanes are preserved (read-modify-write inside the commit edge).
- Loads:
  - The selected lane is right-justified, then extended according to the latched req_signed.
- Memory contents are zero at simulation start and are not cleared by Reset.
- Request inputs are ignored outside IDLE. There is one outstanding request at most.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, counter 0. req_ready is 0 during any cycle Reset is high and 1 in the first cycle after release.
- Latency: accept edge E0 → commit, with resp_valid rising, at edge E0+LATENCY+1.
- Response handshake edge Eh → IDLE. The earliest next accept is edge Eh+1.
- Throughput with resp_ready held at 1: one access per LATENCY+3 cycles.
- A store is visible to any load accepted after its response handshake.
- Backpressure: resp_valid, resp_rdata and resp_err do not change while resp_ready=0.
- Reset mid-operation:
  - Reset in WAIT: the pending store is not committed, and the response is dropped.
  - Reset in RESP: the response is dropped; an already-committed store remains.
- LATENCY=0: WAIT lasts exactly one cycle.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: a misaligned access is detected using the latched fields. Misaligned means a half with addr[0]=1, or a word/size-11 access with addr[1:0]≠00.
  - The access completes with unchanged timing, resp_err=1 and resp_rdata=0.
  - No memory write occurs.
- Undefined: resp_err is tied to 0. Misaligned low address bits are forced to alignment (half clears addr[0]; word clears addr[1:0]) and the access proceeds.

## Test plan
- LATENCY=2, resp_ready=1: sw 0xDEADBEEF @0x10, then lw @0x10 → resp_rdata 0xDEADBEEF. resp_valid rises 3 edges after each accept. req_ready stays low from accept until after the handshake.
- sb 0x80 @0x11 → lb signed @0x11 returns 0xFFFFFF80. lbu @0x11 returns 0x00000080. lw @0x10 returns 0xDEAD80EF.
- sh 0x8001 @0x12 → lh signed returns 0xFFFF8001. lhu returns 0x00008001. lw @0x10 returns 0x800180EF.
- Hold resp_ready=0 for 5 cycles during a load response, and pulse req_valid meanwhile → resp_valid and resp_rdata stay stable, req_ready=0 throughout, and the extra request is not accepted.
- lw @0x13 → with DMEM_MISALIGN_TRAP_EN, resp_err=1, rdata=0, and the word stays 0x800180EF. Without the macro, the same load returns 0x800180EF with resp_err=0.
- sw 0x12345678 @0x20 with Reset asserted in the first WAIT cycle → resp_valid=0 after the reset edge, req_ready=1 after release, and a later lw @0x20 returns 0x00000000.
